// File: rtl/stream_compactor.sv
// stream_compactor
//
// Channel compactor for the capture data path. Channels deselected by
// cfg_mask are removed from each sample. The kept channels are packed
// contiguously toward bit 0 in ascending order, and the upper bits are
// filled with zeros. The compaction is a DL = log2(DW) layer shift network.
// Each layer has its own register and valid flag. The layers sit behind a
// fully back-pressured valid/ready pipeline.
//
// Optional feature, macro STREAM_COMPACTOR_PACK_EN:
//   This adds a packer register stage after the last layer. Let k be the
//   number of kept channels. When k is a power of two and k <= DW/2, the
//   packer concatenates DW/k compacted samples LSB-first into one output
//   word. Otherwise it passes samples through with one extra register.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   ctl_clr         synchronous flush of all in-flight samples
//   ctl_ena         1 = compact, 0 = combinational bypass (also loads cfg)
//   cfg_mask[DW]    1 = channel kept
//   sti_valid/ready/data   input stream
//   sto_valid/ready/data   output stream
module stream_compactor #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ctl_clr,
    input  logic          ctl_ena,
    input  logic [DW-1:0] cfg_mask,
    input  logic          sti_valid,
    output logic          sti_ready,
    input  logic [DW-1:0] sti_data,
    output logic          sto_valid,
    input  logic          sto_ready,
    output logic [DW-1:0] sto_data
);
    localparam int DL = $clog2(DW);
    localparam int SW = DW * DL;

    // Per-bit shift amount: number of dropped channels below that bit.
    function automatic logic [SW-1:0] calc_shift(input logic [DW-1:0] m);
        logic [SW-1:0] s;
        logic [DL-1:0] z;
        s = '0;
        z = '0;
        for (int b = 0; b < DW; b++) begin
            s[b*DL +: DL] = z;
            z = z + {{(DL-1){1'b0}}, ~m[b]};
        end
        return s;
    endfunction

    function automatic logic [DL:0] popcnt(input logic [DW-1:0] m);
        logic [DL:0] c;
        c = '0;
        for (int b = 0; b < DW; b++) begin
            c = c + {{DL{1'b0}}, m[b]};
        end
        return c;
    endfunction

    // Configuration snapshot. It tracks cfg_mask only while bypassed, so a
    // mask change never corrupts samples already in the network. The mask
    // resets to all ones so that the zero shift table acts as identity.
    logic [SW-1:0] r_shift;
    logic [DW-1:0] r_mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_mask  <= '1;
        end else if (!ctl_ena) begin
            r_shift <= calc_shift(cfg_mask);
            r_mask  <= cfg_mask;
        end
    end

    // Layer registers. Layer l holds the result of applying shift bit l.
    logic [DW-1:0] r_dat  [DL];
    logic [DW-1:0] r_keep [DL];
    logic [SW-1:0] r_sh   [DL];
    logic [DL-1:0] r_vld;

    logic [DW-1:0] w_ndat  [DL];
    logic [DW-1:0] w_nkeep [DL];
    logic [SW-1:0] w_nsh   [DL];
    logic [DL-1:0] w_rdy;
    logic [DL-1:0] w_vin;
    logic          w_rdy_tail;
    logic          w_tail_vld;
    logic [DW-1:0] w_tail_dat;

    assign w_vin = {r_vld[DL-2:0], sti_valid};

    // ready[l] = ~valid[l] | ready[l+1]. This is unrolled from the tail so
    // that no signal depends on itself.
    always_comb begin
        logic v_rdy;
        v_rdy = w_rdy_tail;
        for (int l = DL - 1; l >= 0; l--) begin
            v_rdy    = v_rdy | ~r_vld[l];
            w_rdy[l] = v_rdy;
        end
    end

    for (genvar l = 0; l < DL; l++) begin : g_layer
        localparam int STEP = 2 ** l;
        logic [DW-1:0] w_dat;
        logic [DW-1:0] w_keep;
        logic [DW-1:0] w_bit;
        logic [DW-1:0] w_stay;
        logic [DW-1:0] w_mv;
        logic [SW-1:0] w_sh;
        logic [SW-1:0] w_sh_stay;
        logic [SW-1:0] w_sh_mv;

        // Stage boundary: layer 0 takes the input sample and zeroes the
        // dropped channels. Later layers take the previous layer register.
        if (l == 0) begin : g_src0
            assign w_dat  = sti_data & r_mask;
            assign w_keep = r_mask;
            assign w_sh   = r_shift;
        end else begin : g_srcn
            assign w_dat  = r_dat[l-1];
            assign w_keep = r_keep[l-1];
            assign w_sh   = r_sh[l-1];
        end

        always_comb begin
            for (int b = 0; b < DW; b++) begin
                w_bit[b] = w_sh[b*DL + l];
            end
        end

        assign w_stay = w_keep & ~w_bit;
        assign w_mv   = w_keep & w_bit;

        // The shift amounts move together with their kept bits. Slots
        // that are left empty carry zero.
        always_comb begin
            for (int b = 0; b < DW; b++) begin
                w_sh_stay[b*DL +: DL] = w_stay[b] ? w_sh[b*DL +: DL] : '0;
                w_sh_mv[b*DL +: DL]   = w_mv[b]   ? w_sh[b*DL +: DL] : '0;
            end
        end

        assign w_ndat[l]  = (w_dat & w_stay) | ((w_dat & w_mv) >> STEP);
        assign w_nkeep[l] = w_stay | (w_mv >> STEP);
        assign w_nsh[l]   = w_sh_stay | (w_sh_mv >> (STEP * DL));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            for (int l = 0; l < DL; l++) begin
                r_dat[l]  <= '0;
                r_keep[l] <= '0;
                r_sh[l]   <= '0;
            end
        end else if (ctl_clr) begin
            r_vld <= '0;
        end else if (ctl_ena) begin
            for (int l = 0; l < DL; l++) begin
                if (w_rdy[l]) begin
                    r_vld[l]  <= w_vin[l];
                    r_dat[l]  <= w_ndat[l];
                    r_keep[l] <= w_nkeep[l];
                    r_sh[l]   <= w_nsh[l];
                end
            end
        end
    end

`ifdef STREAM_COMPACTOR_PACK_EN
    // Stage boundary: the packer register after the last layer.
    logic [DL:0]   r_k;
    logic          r_pk_vld;
    logic [DW-1:0] r_pk_dat;
    logic [DW-1:0] r_pk_acc;
    logic [DL:0]   r_pk_pos;
    logic          w_pack;
    logic          w_pk_in;
    logic          w_pk_full;
    logic [DW-1:0] w_pk_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k <= (DL+1)'(DW);
        end else if (!ctl_ena) begin
            r_k <= popcnt(cfg_mask);
        end
    end

    assign w_rdy_tail = ~r_pk_vld | sto_ready;
    assign w_pack     = (r_k != '0) && ((r_k & (r_k - (DL+1)'(1))) == '0)
                        && (r_k <= (DL+1)'(DW / 2));
    assign w_pk_in    = ctl_ena & ~ctl_clr & r_vld[DL-1] & w_rdy_tail;
    assign w_pk_word  = r_pk_acc | (r_dat[DL-1] << r_pk_pos);
    // The word is complete when this sample fills the top k bits.
    assign w_pk_full  = ({1'b0, r_pk_pos} + {1'b0, r_k}) == (DL+2)'(DW);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pk_vld <= 1'b0;
            r_pk_dat <= '0;
            r_pk_acc <= '0;
            r_pk_pos <= '0;
        end else if (ctl_clr) begin
            r_pk_vld <= 1'b0;
            r_pk_acc <= '0;
            r_pk_pos <= '0;
        end else if (ctl_ena) begin
            if (sto_ready) begin
                r_pk_vld <= 1'b0;
            end
            if (w_pk_in) begin
                if (!w_pack) begin
                    r_pk_dat <= r_dat[DL-1];
                    r_pk_vld <= 1'b1;
                end else if (w_pk_full) begin
                    r_pk_dat <= w_pk_word;
                    r_pk_vld <= 1'b1;
                    r_pk_acc <= '0;
                    r_pk_pos <= '0;
                end else begin
                    r_pk_acc <= w_pk_word;
                    r_pk_pos <= r_pk_pos + r_k;
                end
            end
        end
    end

    assign w_tail_vld = r_pk_vld;
    assign w_tail_dat = r_pk_dat;
`else
    assign w_rdy_tail = sto_ready;
    assign w_tail_vld = r_vld[DL-1];
    assign w_tail_dat = r_dat[DL-1];
`endif

    // Bypass is fully combinational. The pipeline contents stay frozen.
    assign sti_ready = ~ctl_clr & (ctl_ena ? w_rdy[0] : sto_ready);
    assign sto_valid = ctl_ena ? w_tail_vld : (sti_valid & ~ctl_clr);
    assign sto_data  = ctl_ena ? w_tail_dat : sti_data;

endmodule

// File: tb/tb_stream_compactor.sv
module tb_stream_compactor;
    localparam int DW = 32;
    localparam int DL = 5;
`ifdef STREAM_COMPACTOR_PACK_EN
    localparam int LAT = DL + 1;
`else
    localparam int LAT = DL;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ctl_clr = 1'b0;
    logic          ctl_ena = 1'b1;
    logic [DW-1:0] cfg_mask = '1;
    logic          sti_valid = 1'b0;
    logic          sti_ready;
    logic [DW-1:0] sti_data = '0;
    logic          sto_valid;
    logic          sto_ready = 1'b1;
    logic [DW-1:0] sto_data;

    int n_chk = 0;
    int n_pass = 0;

    stream_compactor #(.DW(DW)) dut (
        .clk(clk), .rst(rst), .ctl_clr(ctl_clr), .ctl_ena(ctl_ena),
        .cfg_mask(cfg_mask), .sti_valid(sti_valid), .sti_ready(sti_ready),
        .sti_data(sti_data), .sto_valid(sto_valid), .sto_ready(sto_ready),
        .sto_data(sto_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] mask;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

`ifdef STREAM_COMPACTOR_PACK_EN
    function automatic bit packs(input logic [31:0] m);
        int k;
        k = $countones(m);
        return (k != 0) && ((k & (k - 1)) == 0) && (k <= DW / 2);
    endfunction
`endif

    task automatic load_mask(input logic [31:0] m);
        @(negedge clk);
        ctl_ena = 1'b0;
        cfg_mask = m;
        sti_valid = 1'b0;
        @(negedge clk);
        ctl_ena = 1'b1;
    endtask

    task automatic send_one(input string nm, input logic [31:0] d, input logic [31:0] exp);
        int cyc;
        @(negedge clk);
        sto_ready = 1'b1;
        sti_valid = 1'b1;
        sti_data = d;
        #1 chk({nm, "_rdy"}, sti_ready, 1);
        @(posedge clk);
        cyc = 1;
        #1 sti_valid = 1'b0;
        @(negedge clk);
        while (!sto_valid && cyc < 30) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        chk({nm, "_lat"}, cyc, LAT);
        chk({nm, "_data"}, sto_data, exp);
    endtask

    task automatic run_stream(input int n, input bit rnd, output int first_out,
                              output int last_out, output int stalls);
        int sent;
        int rcv;
        int cyc;
        logic ih;
        logic oh;
        sent = 0; rcv = 0; cyc = 0; stalls = 0;
        first_out = -1; last_out = -1;
        while (rcv < n && cyc < 3000) begin
            @(negedge clk);
            sto_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            sti_valid = (sent < n);
            sti_data = sent;
            #1;
            ih = sti_valid & sti_ready;
            oh = sto_valid & sto_ready;
            if (sti_valid && !sti_ready) stalls++;
            if (oh) begin
                chk($sformatf("stream_item%0d", rcv), sto_data, rcv);
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                rcv++;
            end
            if (ih) sent++;
            cyc++;
        end
        sti_valid = 1'b0;
        sto_ready = 1'b1;
        chk("stream_count", rcv, n);
    endtask

    initial begin
        int fo, lo, st, seen, cyc;
        logic [31:0] smask;
        bit skip;

        vecs[0] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5678};
        vecs[1] = '{32'h0000_FF00, 32'hA5A5_3C00, 32'h0000_003C};
        vecs[2] = '{32'hF0F0_0000, 32'h1234_5678, 32'h0000_0013};
        vecs[3] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[4] = '{32'h8000_0001, 32'h8000_0001, 32'h0000_0003};
        vecs[5] = '{32'hAAAA_AAAA, 32'hFFFF_0000, 32'h0000_FF00};
        vecs[6] = '{32'h0F0F_0F0F, 32'h1234_5678, 32'h0000_2468};
        vecs[7] = '{32'h5555_5555, 32'h0000_000F, 32'h0000_0003};

        // reset state, then bypass while still in reset
        #12;
        chk("rst_sto_valid", sto_valid, 0);
        chk("rst_sti_ready", sti_ready, 1);
        ctl_ena = 1'b0;
        sti_valid = 1'b1;
        sti_data = 32'hCAFE_0001;
        #1 chk("rst_bypass_valid", sto_valid, 1);
        chk("rst_bypass_data", sto_data, 32'hCAFE_0001);
        sti_valid = 1'b0;
        ctl_ena = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // table-driven single samples
        for (int i = 0; i < 8; i++) begin
            skip = 1'b0;
`ifdef STREAM_COMPACTOR_PACK_EN
            skip = packs(vecs[i].mask);
`endif
            if (!skip) begin
                load_mask(vecs[i].mask);
                send_one($sformatf("vec%0d", i), vecs[i].data, vecs[i].exp);
            end
        end

        // mask changes while enabled must be ignored
        load_mask(32'h0000_01FF);
        @(negedge clk);
        cfg_mask = 32'hFFFF_FFFF;
        send_one("freeze", 32'hABCD_1234, 32'h0000_0034);

        // random back-pressure stream, then full throughput
`ifdef STREAM_COMPACTOR_PACK_EN
        smask = 32'h0001_FFFF;
`else
        smask = 32'h0000_FFFF;
`endif
        load_mask(smask);
        run_stream(100, 1'b1, fo, lo, st);
        run_stream(20, 1'b0, fo, lo, st);
        chk("tput_out_span", lo - fo, 19);
        chk("tput_in_stalls", st, 0);

`ifdef STREAM_COMPACTOR_PACK_EN
        // four 8-bit samples packed into one word
        load_mask(32'h0000_00FF);
        sto_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sti_valid = 1'b1;
            sti_data = (i + 1) * 32'h11;
        end
        @(posedge clk);
        cyc = 1;
        #1 sti_valid = 1'b0;
        @(negedge clk);
        while (!sto_valid && cyc < 30) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        chk("pack_lat", cyc, DL + 1);
        chk("pack_word", sto_data, 32'h4433_2211);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (sto_valid) seen++;
        end
        chk("pack_single_word", seen, 0);
`endif

        // flush three in-flight samples, then bypass
        load_mask(32'hFFFF_FFFF);
        sto_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sti_valid = 1'b1;
            sti_data = 32'h100 + i;
        end
        @(negedge clk);
        ctl_clr = 1'b1;
        sti_data = 32'h999;
        #1 chk("clr_sti_ready", sti_ready, 0);
        @(negedge clk);
        ctl_clr = 1'b0;
        sti_valid = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (sto_valid) seen++;
        end
        chk("clr_no_output", seen, 0);
        ctl_ena = 1'b0;
        sti_valid = 1'b1;
        sti_data = 32'hDEAD_BEEF;
        #1 chk("bypass_valid", sto_valid, 1);
        chk("bypass_data", sto_data, 32'hDEAD_BEEF);
        @(negedge clk);
        sti_valid = 1'b0;
        ctl_ena = 1'b1;

        // asynchronous reset with a stalled, full pipeline
        sto_ready = 1'b0;
        cyc = 0;
        while (!sto_valid && cyc < 20) begin
            @(negedge clk);
            sti_valid = 1'b1;
            sti_data = 32'h200 + cyc;
            cyc++;
        end
        chk("pre_rst_valid", sto_valid, 1);
        rst = 1'b1;
        #1 chk("async_rst_valid", sto_valid, 0);
        @(negedge clk);
        sti_valid = 1'b0;
        sto_ready = 1'b1;
        rst = 1'b0;
        send_one("post_rst", 32'h0F0F_1234, 32'h0F0F_1234);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
